fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32, shall set the width of pc and mem_addr.
REQ-002 Parameter TIMEOUT_CYC, default 16, shall set the number of cycles without mem_ack before a fetch is abandoned (used only with FETCH_TIMEOUT_EN).
REQ-003 The block shall use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 pc  in  ADDR_W  byte address of the requested instruction.
REQ-007 fetch_req  in  1  core requests the instruction at pc; sampled only in IDLE.
REQ-008 flush  in  1  branch/jump redirect; discards any in-flight fetch.
REQ-009 instruction  out  32  last fetched instruction word, registered.
REQ-010 inst_valid  out  1  one-cycle pulse; instruction is new this cycle.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 mem_req  out  1  memory read request, held until mem_ack.
REQ-013 mem_addr  out  ADDR_W  word-aligned read address, stable while mem_req=1.
REQ-014 mem_ack  in  1  memory returns mem_rdata this cycle.
REQ-015 mem_rdata  in  32  read data, valid only when mem_ack=1.
REQ-016 fetch_err  out  1  one-cycle timeout pulse; port exists only with FETCH_TIMEOUT_EN.

Function
REQ-017 FSM states: IDLE, REQ, RESP, DROP.
REQ-018 IDLE: fetch_req=1, flush=0, pc[1:0]=0 -> latch pc into mem_addr, go to REQ.
REQ-019 IDLE: fetch_req=1, pc[1:0]!=0 -> no memory access; load instruction=0x00000013 (NOP), go to RESP.
REQ-020 REQ: drive mem_req=1; on mem_ack=1, capture mem_rdata into instruction and go to RESP; otherwise stay.
REQ-021 RESP: inst_valid=1 for exactly one cycle, then go to IDLE; fetch_req is not accepted in RESP.
REQ-022 Minimum latency: fetch_req accepted at cycle N, mem_ack at N+1, inst_valid at N+2.
REQ-023 fetch_req while busy=1 shall be ignored, with no queuing.
REQ-024 flush in IDLE shall take priority over a same-cycle fetch_req (request dropped).
REQ-025 flush in REQ with mem_ack=0 -> go to DROP; DROP holds mem_req=1 until mem_ack, discards mem_rdata, then goes to IDLE with no inst_valid.
REQ-026 flush in REQ with mem_ack=1 -> data discarded, instruction unchanged, go to IDLE.
REQ-027 flush in RESP shall force inst_valid=0 that cycle; the FSM still returns to IDLE.
REQ-028 instruction shall hold its value except on capture in REQ or the misaligned/timeout NOP load.
REQ-029 mem_ack outside REQ/DROP shall be ignored.

Reset
REQ-030 rst=1 at a clock edge -> state IDLE, instruction=0x00000013, inst_valid=0, busy=0, mem_req=0, mem_addr=0, fetch_err=0, timeout counter=0.
REQ-031 Reset mid-transaction shall abandon the transaction without waiting for mem_ack; a late mem_ack is ignored per REQ-029.

Configuration
REQ-032 Macro FETCH_TIMEOUT_EN defined: a counter increments each cycle in REQ/DROP, clears on state entry, and at TIMEOUT_CYC without mem_ack deasserts mem_req and goes to RESP (from REQ: instruction=NOP, fetch_err=1 with inst_valid) or to IDLE (from DROP: fetch_err=1 only).
REQ-033 Macro undefined: no counter and no fetch_err port; REQ and DROP wait indefinitely.

Structure
REQ-034 Package fetch_pkg shall hold the state enum, NOP_INSN=32'h00000013 and the word-align mask.
REQ-035 Sub-module fetch_timer (timeout counter) shall be instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-036 pc=0x10, fetch_req pulse, mem_ack one cycle later with rdata=0x3e800093 -> mem_addr=0x10, inst_valid at N+2, instruction=0x3e800093.
REQ-037 mem_ack delayed 5 cycles -> mem_req and mem_addr stable for all 5 cycles, single inst_valid pulse.
REQ-038 flush 2 cycles into a 5-cycle wait -> mem_req held until ack, no inst_valid, instruction unchanged, busy drops the cycle after ack.
REQ-039 pc=0x12 -> no mem_req, instruction=0x00000013, inst_valid pulse.
REQ-040 With FETCH_TIMEOUT_EN and TIMEOUT_CYC=4, no ack -> mem_req drops after 4 cycles, fetch_err and inst_valid pulse together, instruction=0x00000013.
REQ-041 rst asserted during REQ, then ack 1 cycle later -> all outputs at reset values, no inst_valid.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSN        = 32'h0000_0013;
    // Byte-offset bits inside a 32-bit word; clearing them word-aligns an address.
    localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;

    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return ((lsb & WORD_ALIGN_MASK) == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// Cycle counter that flags an abandoned memory read; used only with FETCH_TIMEOUT_EN.
module fetch_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] count_r;

    // Count cycles spent waiting; restart whenever a waiting state is (re)entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear || !run) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + 1'b1;
        end
    end

    assign expired = run && (count_r == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with flush handling.
// Optional abandon-on-timeout behaviour and fetch_err port enabled by FETCH_TIMEOUT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              fetch_req,
    input  logic              flush,
    output logic [31:0]       instruction,
    output logic              inst_valid,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic              fetch_err
`endif
);

    fetch_state_e state_r;
    logic         valid_r;
    logic         timeout_s;
    logic         abandon_s;

`ifdef FETCH_TIMEOUT_EN
    logic timer_clear_s;

    // Moving REQ -> DROP keeps mem_req high, so the timer must be told to restart.
    assign timer_clear_s = (state_r == ST_REQ) && flush && !mem_ack;

    fetch_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_fetch_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear_s),
        .run     (mem_req),
        .expired (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // An ack or a flush in REQ outranks an expiring timer.
    assign abandon_s = timeout_s && !mem_ack &&
                       ((state_r == ST_DROP) || ((state_r == ST_REQ) && !flush));

    // Fetch sequencing: state, captured instruction and memory handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            instruction <= NOP_INSN;
            valid_r     <= 1'b0;
            busy        <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    valid_r <= 1'b0;
                    if (fetch_req && !flush) begin
                        busy <= 1'b1;
                        if (is_word_aligned(pc[1:0])) begin
                            state_r  <= ST_REQ;
                            mem_req  <= 1'b1;
                            mem_addr <= {pc[ADDR_W-1:2], pc[1:0] & ~WORD_ALIGN_MASK};
                        end else begin
                            state_r     <= ST_RESP;
                            instruction <= NOP_INSN;
                            valid_r     <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (flush) begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            state_r     <= ST_RESP;
                            instruction <= mem_rdata;
                            valid_r     <= 1'b1;
                        end
                    end else if (flush) begin
                        state_r <= ST_DROP;
                    end else if (abandon_s) begin
                        state_r     <= ST_RESP;
                        mem_req     <= 1'b0;
                        instruction <= NOP_INSN;
                        valid_r     <= 1'b1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    busy    <= 1'b0;
                end
                ST_DROP: begin
                    if (mem_ack || abandon_s) begin
                        state_r <= ST_IDLE;
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Timeout pulse coincides with the NOP response (REQ) or the return to IDLE (DROP).
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_err <= 1'b0;
        end else begin
            fetch_err <= abandon_s;
        end
    end
`endif

    // A redirect arriving in the response cycle cancels the delivery.
    assign inst_valid = valid_r && !flush;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized transactions
// checked against a per-transaction timeline model.
module tb_fetch_unit;

    localparam int          AW    = 32;
    localparam int          TO    = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef FETCH_TIMEOUT_EN
    localparam int          MAXW  = TO;
`else
    localparam int          MAXW  = 8;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc;
    logic          fetch_req;
    logic          flush;
    logic [31:0]   instruction;
    logic          inst_valid;
    logic          busy;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
`ifdef FETCH_TIMEOUT_EN
    logic          fetch_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: what the core should currently see.
    logic [31:0] m_instr;
    logic [31:0] m_addr;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W      (AW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .fetch_req   (fetch_req),
        .flush       (flush),
        .instruction (instruction),
        .inst_valid  (inst_valid),
        .busy        (busy),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
`ifdef FETCH_TIMEOUT_EN
        ,
        .fetch_err   (fetch_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: let inputs settle, compare outputs, then advance past the edge.
    task automatic cyc(input string tag, input logic e_req, input logic [31:0] e_addr,
                       input logic e_busy, input logic e_valid, input logic [31:0] e_instr,
                       input logic e_err);
        #1;
        chk({tag, ".mem_req"},     {31'd0, mem_req},    {31'd0, e_req});
        chk({tag, ".mem_addr"},    mem_addr,            e_addr);
        chk({tag, ".busy"},        {31'd0, busy},       {31'd0, e_busy});
        chk({tag, ".inst_valid"},  {31'd0, inst_valid}, {31'd0, e_valid});
        chk({tag, ".instruction"}, instruction,         e_instr);
`ifdef FETCH_TIMEOUT_EN
        chk({tag, ".fetch_err"},   {31'd0, fetch_err},  {31'd0, e_err});
`else
        if (e_err) chk({tag, ".fetch_err_unsupported"}, 32'd0, 32'd1);
`endif
        @(posedge clk);
        #1;
    endtask

    // One fetch: w = cycles waiting for the ack (ack in the last), f = cycle carrying a
    // flush (0 = same cycle as the request, -1 = none), noise = ignored fetch_req/ack traffic.
    task automatic txn(input logic [31:0] a, input int w, input logic [31:0] d,
                       input int f, input bit noise);
        bit drop;
        fetch_req = 1'b1;
        pc        = a;
        flush     = (f == 0);
        mem_ack   = 1'b0;
        cyc("req_cycle", 1'b0, m_addr, 1'b0, 1'b0, m_instr, 1'b0);
        fetch_req = 1'b0;
        flush     = 1'b0;
        if (f != 0) begin
            if (a[1:0] != 2'b00) begin
                m_instr = NOP;
                flush   = (f == 1);
                if (noise) begin
                    fetch_req = 1'b1;
                    pc        = $urandom;
                    mem_ack   = 1'b1;
                    mem_rdata = $urandom;
                end
                cyc("misaligned_resp", 1'b0, m_addr, 1'b1, (f != 1), m_instr, 1'b0);
            end else begin
                m_addr = a;
                for (int i = 1; i <= w; i++) begin
                    flush     = (i == f);
                    mem_ack   = (i == w);
                    mem_rdata = (i == w) ? d : $urandom;
                    fetch_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                    pc        = $urandom;
                    cyc("wait", 1'b1, m_addr, 1'b1, 1'b0, m_instr, 1'b0);
                end
                drop = (f >= 1) && (f <= w);
                if (!drop) begin
                    m_instr   = d;
                    flush     = (f == w + 1);
                    mem_ack   = noise;
                    mem_rdata = $urandom;
                    fetch_req = noise;
                    cyc("resp", 1'b0, m_addr, 1'b1, (f != w + 1), m_instr, 1'b0);
                end
            end
        end
        flush     = 1'b0;
        fetch_req = 1'b0;
        mem_ack   = noise;
        mem_rdata = $urandom;
        cyc("back_idle", 1'b0, m_addr, 1'b0, 1'b0, m_instr, 1'b0);
        mem_ack   = 1'b0;
    endtask

    initial begin
        int w;
        int f;
        int r;
        logic [31:0] a;

        rst       = 1'b1;
        pc        = '0;
        fetch_req = 1'b0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        m_instr   = NOP;
        m_addr    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("reset", 1'b0, 32'd0, 1'b0, 1'b0, NOP, 1'b0);

        // Minimum-latency fetch, long wait, flushed wait, misaligned pc.
        txn(32'h0000_0010, 1, 32'h3e80_0093, -1, 1'b0);
        txn(32'h0000_0020, 5, 32'hdead_beef, -1, 1'b0);
        txn(32'h0000_0030, 5, 32'h1234_5678,  2, 1'b0);
        txn(32'h0000_0012, 1, 32'h0,         -1, 1'b0);
        txn(32'h0000_0040, 3, 32'hcafe_f00d,  0, 1'b1);
        txn(32'h0000_0044, 2, 32'h0bad_c0de,  2, 1'b1);
        txn(32'h0000_0048, 2, 32'h5555_aaaa,  3, 1'b1);

        // Reset while a read is outstanding; the late ack must be ignored.
        fetch_req = 1'b1;
        pc        = 32'h0000_0100;
        cyc("rst_accept", 1'b0, m_addr, 1'b0, 1'b0, m_instr, 1'b0);
        fetch_req = 1'b0;
        m_addr    = 32'h0000_0100;
        cyc("rst_req", 1'b1, m_addr, 1'b1, 1'b0, m_instr, 1'b0);
        rst = 1'b1;
        cyc("rst_edge", 1'b1, m_addr, 1'b1, 1'b0, m_instr, 1'b0);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_7777;
        m_instr   = NOP;
        m_addr    = '0;
        cyc("rst_late_ack", 1'b0, 32'd0, 1'b0, 1'b0, NOP, 1'b0);
        mem_ack = 1'b0;
        cyc("rst_settled", 1'b0, 32'd0, 1'b0, 1'b0, NOP, 1'b0);

`ifdef FETCH_TIMEOUT_EN
        // No ack from REQ: NOP delivered with fetch_err after TO cycles.
        fetch_req = 1'b1;
        pc        = 32'h0000_0080;
        cyc("to_accept", 1'b0, m_addr, 1'b0, 1'b0, m_instr, 1'b0);
        fetch_req = 1'b0;
        m_addr    = 32'h0000_0080;
        for (int i = 0; i < TO; i++) cyc("to_wait", 1'b1, m_addr, 1'b1, 1'b0, m_instr, 1'b0);
        m_instr = NOP;
        cyc("to_resp", 1'b0, m_addr, 1'b1, 1'b1, NOP, 1'b1);
        cyc("to_idle", 1'b0, m_addr, 1'b0, 1'b0, NOP, 1'b0);

        // No ack after a flush: DROP gives up after TO cycles, error only.
        fetch_req = 1'b1;
        pc        = 32'h0000_0084;
        cyc("tod_accept", 1'b0, m_addr, 1'b0, 1'b0, m_instr, 1'b0);
        fetch_req = 1'b0;
        m_addr    = 32'h0000_0084;
        flush     = 1'b1;
        cyc("tod_flush", 1'b1, m_addr, 1'b1, 1'b0, m_instr, 1'b0);
        flush = 1'b0;
        for (int i = 0; i < TO; i++) cyc("tod_drop", 1'b1, m_addr, 1'b1, 1'b0, m_instr, 1'b0);
        cyc("tod_err", 1'b0, m_addr, 1'b0, 1'b0, m_instr, 1'b1);
        cyc("tod_idle", 1'b0, m_addr, 1'b0, 1'b0, m_instr, 1'b0);
`endif

        // Randomized transactions.
        for (int t = 0; t < 80; t++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            w = $urandom_range(1, MAXW);
            r = $urandom_range(0, 9);
            if (r < 5)       f = -1;
            else if (r == 5) f = 0;
            else             f = $urandom_range(1, w + 1);
            txn(a, w, $urandom, f, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
